// File: rtl/dma_r_chunked.sv
// DMA read engine (external memory -> OCM): queued commands, chunked ami reads that never cross a CHUNK_BYTES source boundary.
// Optional counters perf_cycles/perf_beats are built when DMA_R_CHUNKED_PERF_EN is defined.
module dma_r_chunked #(
    parameter int AXI_DW      = 128,
    parameter int CHUNK_BYTES = 4096,
    parameter int CMD_DEPTH   = 4
) (
    input  logic                         usr_clk,
    input  logic                         usr_reset_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [31:0]                  cfg_src_sa,
    input  logic [31:0]                  cfg_dst_sa,
    input  logic [31:0]                  cfg_len,
    output logic                         dmar_valid,
    input  logic                         dmar_ready,
    output logic [31:0]                  dmar_sa,
    output logic [31:0]                  dmar_len,
    input  logic [AXI_DW-1:0]            dma_rdata,
    input  logic                         dma_rlast,
    input  logic                         dma_rvalid,
    output logic                         dma_rready,
    output logic                         ram_we,
    output logic [31:0]                  ram_a,
    output logic [AXI_DW-1:0]            ram_d,
    output logic [AXI_DW/8-1:0]          ram_be,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    input  logic                         err_clr,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count
`ifdef DMA_R_CHUNKED_PERF_EN
    ,
    output logic [31:0]                  perf_cycles,
    output logic [31:0]                  perf_beats
`endif
);

    localparam int BYTES = AXI_DW / 8;
    localparam int L     = $clog2(BYTES);
    localparam int PW    = $clog2(CMD_DEPTH);
    localparam logic [31:0] BYTES_W   = 32'(BYTES);
    localparam logic [31:0] CHUNK_W   = 32'(CHUNK_BYTES);
    localparam logic [31:0] ADDR_MASK = ~(BYTES_W - 32'd1);
    localparam logic [PW:0] DEPTH_W   = (PW+1)'(CMD_DEPTH);
    localparam logic [BYTES-1:0] BE_ONES = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_DATA, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic [31:0]   r_q_src [CMD_DEPTH];
    logic [31:0]   r_q_dst [CMD_DEPTH];
    logic [31:0]   r_q_len [CMD_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;

    logic [31:0]  r_src, r_dst, r_rem, r_exp, r_bc;
    logic [L-1:0] r_tail;
    logic         r_err;

    logic         w_push, w_pop, w_beat, w_wr, w_err_set, w_final_beat;
    logic [31:0]  w_room, w_clen, w_exp_nxt, w_head_len;
    logic [BYTES-1:0] w_be;

    assign w_push     = cfg_valid && cfg_ready;
    assign w_pop      = (r_state == S_LOAD);
    assign w_head_len = r_q_len[r_rptr];

    // Chunk length is bounded by the bytes left and the distance to the next source boundary.
    assign w_room    = CHUNK_W - (r_src & (CHUNK_W - 32'd1));
    assign w_clen    = (r_rem < w_room) ? r_rem : w_room;
    assign w_exp_nxt = (w_clen + BYTES_W - 32'd1) >> L;

    assign w_beat       = (r_state == S_DATA) && dma_rvalid;
    assign w_wr         = w_beat && (r_bc < r_exp);
    assign w_err_set    = w_beat && dma_rlast && (r_bc != (r_exp - 32'd1));
    assign w_final_beat = (r_rem == w_clen) && (r_bc == (r_exp - 32'd1));
    assign w_be         = (w_final_beat && (r_tail != '0))
                          ? (BE_ONES >> (BYTES_W - {{(32-L){1'b0}}, r_tail})) : BE_ONES;

    assign cfg_ready = (r_count != DEPTH_W);
    assign cmd_count = r_count;
    assign busy      = (r_count != '0) || (r_state != S_IDLE);
    assign err       = r_err;

    // Command queue storage (contents need no reset, validity is tracked by r_count).
    always_ff @(posedge usr_clk) begin
        if (w_push) begin
            r_q_src[r_wptr] <= cfg_src_sa;
            r_q_dst[r_wptr] <= cfg_dst_sa;
            r_q_len[r_wptr] <= cfg_len;
        end
    end

    // Command queue pointers and fill level.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_count != '0) w_state_nxt = S_LOAD; else w_state_nxt = S_IDLE;
            S_LOAD: if (w_head_len == 32'd0) w_state_nxt = S_DONE; else w_state_nxt = S_REQ;
            S_REQ:  if (dmar_ready) w_state_nxt = S_DATA; else w_state_nxt = S_REQ;
            S_DATA: begin
                if (w_beat && dma_rlast) w_state_nxt = ((r_rem - w_clen) != 32'd0) ? S_REQ : S_DONE;
                else                     w_state_nxt = S_DATA;
            end
            S_DONE: if (r_count != '0) w_state_nxt = S_LOAD; else w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer datapath: addresses, remaining bytes, beat accounting.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            r_src  <= 32'd0;
            r_dst  <= 32'd0;
            r_rem  <= 32'd0;
            r_exp  <= 32'd0;
            r_bc   <= 32'd0;
            r_tail <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_src  <= r_q_src[r_rptr] & ADDR_MASK;
                    r_dst  <= r_q_dst[r_rptr] & ADDR_MASK;
                    r_rem  <= w_head_len;
                    r_tail <= w_head_len[L-1:0];
                end
                S_REQ: begin
                    if (dmar_ready) begin
                        r_exp <= w_exp_nxt;
                        r_bc  <= 32'd0;
                    end
                end
                S_DATA: begin
                    if (w_beat) r_bc <= r_bc + 32'd1;
                    if (w_wr)   r_dst <= r_dst + BYTES_W;
                    // An early rlast still retires the whole chunk.
                    if (w_beat && dma_rlast) begin
                        r_src <= r_src + w_clen;
                        r_rem <= r_rem - w_clen;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky framing error; a set wins over a simultaneous clear.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n)   r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
        else if (err_clr)   r_err <= 1'b0;
        else                r_err <= r_err;
    end

    // State-decoded request, data and RAM outputs.
    always_comb begin
        dmar_valid = 1'b0;
        dmar_sa    = 32'd0;
        dmar_len   = 32'd0;
        dma_rready = 1'b0;
        ram_we     = 1'b0;
        ram_a      = 32'd0;
        ram_d      = '0;
        ram_be     = '0;
        done       = 1'b0;
        case (r_state)
            S_REQ: begin
                dmar_valid = 1'b1;
                dmar_sa    = r_src;
                dmar_len   = w_clen;
            end
            S_DATA: begin
                dma_rready = 1'b1;
                if (w_wr) begin
                    ram_we = 1'b1;
                    ram_a  = r_dst;
                    ram_d  = dma_rdata;
                    ram_be = w_be;
                end else begin
                    ram_we = 1'b0;
                end
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

`ifdef DMA_R_CHUNKED_PERF_EN
    logic [31:0] r_perf_cycles, r_perf_beats;

    // Saturating activity counters.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            r_perf_cycles <= 32'd0;
            r_perf_beats  <= 32'd0;
        end else begin
            if (busy && (r_perf_cycles != 32'hFFFF_FFFF))  r_perf_cycles <= r_perf_cycles + 32'd1;
            if (ram_we && (r_perf_beats != 32'hFFFF_FFFF)) r_perf_beats  <= r_perf_beats + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_beats  = r_perf_beats;
`endif

endmodule

// File: tb/tb_dma_r_chunked.sv
// Directed bench for dma_r_chunked: the bench plays the ami read slave and logs RAM writes, requests and done pulses.
module tb_dma_r_chunked;

    logic         usr_clk = 1'b0;
    logic         usr_reset_n;
    logic         cfg_valid, cfg_ready;
    logic [31:0]  cfg_src_sa, cfg_dst_sa, cfg_len;
    logic         dmar_valid, dmar_ready;
    logic [31:0]  dmar_sa, dmar_len;
    logic [127:0] dma_rdata;
    logic         dma_rlast, dma_rvalid, dma_rready;
    logic         ram_we;
    logic [31:0]  ram_a;
    logic [127:0] ram_d;
    logic [15:0]  ram_be;
    logic         busy, done, err, err_clr;
    logic [2:0]   cmd_count;

    int n_checks = 0;
    int n_errors = 0;
    int done_n   = 0;
    logic [31:0]  wa_q[$];
    logic [15:0]  wbe_q[$];
    logic [127:0] wd_q[$];
    logic [31:0]  rsa_q[$];
    logic [31:0]  rlen_q[$];
    int wb, rb, db;

    dma_r_chunked #(.AXI_DW(128), .CHUNK_BYTES(4096), .CMD_DEPTH(4)) dut (
        .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_src_sa(cfg_src_sa), .cfg_dst_sa(cfg_dst_sa), .cfg_len(cfg_len),
        .dmar_valid(dmar_valid), .dmar_ready(dmar_ready),
        .dmar_sa(dmar_sa), .dmar_len(dmar_len),
        .dma_rdata(dma_rdata), .dma_rlast(dma_rlast),
        .dma_rvalid(dma_rvalid), .dma_rready(dma_rready),
        .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_be(ram_be),
        .busy(busy), .done(done), .err(err), .err_clr(err_clr),
        .cmd_count(cmd_count)
    );

    always #5 usr_clk = ~usr_clk;

    // Observe handshakes between active edges.
    always @(negedge usr_clk) begin
        if (usr_reset_n) begin
            if (ram_we) begin
                wa_q.push_back(ram_a);
                wbe_q.push_back(ram_be);
                wd_q.push_back(ram_d);
            end
            if (dmar_valid && dmar_ready) begin
                rsa_q.push_back(dmar_sa);
                rlen_q.push_back(dmar_len);
            end
            if (done) done_n++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        wb = wa_q.size();
        rb = rsa_q.size();
        db = done_n;
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        cfg_src_sa = s;
        cfg_dst_sa = d;
        cfg_len    = n;
        cfg_valid  = 1'b1;
        for (int t = 0; t < 200 && !cfg_ready; t++) begin
            @(posedge usr_clk); #1;
        end
        chk("push_ready", cfg_ready, 1'b1);
        @(posedge usr_clk); #1;
        cfg_valid = 1'b0;
    endtask

    // Accept one request, then return nbeats beats with rlast on beat index last_at (-1: none).
    task automatic serve(input int nbeats, input int last_at);
        for (int t = 0; t < 200 && !dmar_valid; t++) begin
            @(posedge usr_clk); #1;
        end
        chk("req_seen", dmar_valid, 1'b1);
        dmar_ready = 1'b1;
        @(posedge usr_clk); #1;
        dmar_ready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            dma_rvalid = 1'b1;
            dma_rdata  = {4{32'hD000_0000 + 32'(i)}};
            dma_rlast  = (i == last_at);
            @(posedge usr_clk); #1;
        end
        dma_rvalid = 1'b0;
        dma_rlast  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300 && busy; t++) begin
            @(posedge usr_clk); #1;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        usr_reset_n = 1'b0;
        cfg_valid = 1'b0; cfg_src_sa = 32'd0; cfg_dst_sa = 32'd0; cfg_len = 32'd0;
        dmar_ready = 1'b0; dma_rdata = 128'd0; dma_rlast = 1'b0; dma_rvalid = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(posedge usr_clk);
        #1;
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_outs", {dmar_valid, dma_rready, ram_we, busy, done, err}, 6'b0);
        chk("rst_cmd_count", cmd_count, 3'd0);
        usr_reset_n = 1'b1;
        @(posedge usr_clk); #1;
        chk("post_rst_busy", busy, 1'b0);

        // Aligned 64-byte transfer, with command-to-request and data-to-done latency.
        snap();
        push(32'h0000_1000, 32'h0000_0000, 32'd64);
        chk("lat_t0", dmar_valid, 1'b0);
        @(posedge usr_clk); #1;
        chk("lat_t1", dmar_valid, 1'b0);
        @(posedge usr_clk); #1;
        chk("lat_t2", dmar_valid, 1'b1);
        serve(4, 3);
        chk("done_lat", done, 1'b1);
        wait_idle();
        chk("t1_nreq", rsa_q.size() - rb, 1);
        chk("t1_req_sa", rsa_q[rb], 32'h1000);
        chk("t1_req_len", rlen_q[rb], 32'd64);
        chk("t1_nwr", wa_q.size() - wb, 4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_wa", wa_q[wb+k], 32'(k * 16));
            chk("t1_be", wbe_q[wb+k], 16'hFFFF);
            chk("t1_wd", wd_q[wb+k], {4{32'hD000_0000 + 32'(k)}});
        end
        chk("t1_done", done_n - db, 1);
        chk("t1_err", err, 1'b0);

        // Transfer crossing a 4 KiB source boundary.
        snap();
        push(32'h0000_0FF0, 32'h0000_0200, 32'h30);
        serve(1, 0);
        serve(2, 1);
        wait_idle();
        chk("t2_nreq", rsa_q.size() - rb, 2);
        chk("t2_req0", {rsa_q[rb], rlen_q[rb]}, {32'h0FF0, 32'd16});
        chk("t2_req1", {rsa_q[rb+1], rlen_q[rb+1]}, {32'h1000, 32'd32});
        chk("t2_nwr", wa_q.size() - wb, 3);
        chk("t2_wa2", wa_q[wb+2], 32'h220);
        chk("t2_done", done_n - db, 1);

        // Partial final beat.
        snap();
        push(32'h0000_2000, 32'h0000_0400, 32'd20);
        serve(2, 1);
        wait_idle();
        chk("t3_req", {rsa_q[rb], rlen_q[rb]}, {32'h2000, 32'd20});
        chk("t3_nwr", wa_q.size() - wb, 2);
        chk("t3_be0", wbe_q[wb], 16'hFFFF);
        chk("t3_wa1", wa_q[wb+1], 32'h410);
        chk("t3_be1", wbe_q[wb+1], 16'h000F);

        // Queue fill with a stalled request slave, including zero-length commands.
        snap();
        push(32'h0000_3000, 32'h0000_0500, 32'd32);
        push(32'h0000_0000, 32'h0000_0600, 32'd0);
        push(32'h0000_4000, 32'h0000_0700, 32'd16);
        push(32'h0000_0000, 32'h0000_0800, 32'd0);
        push(32'h0000_5000, 32'h0000_0900, 32'd48);
        chk("t4_count_peak", cmd_count, 3'd4);
        chk("t4_ready_full", cfg_ready, 1'b0);
        repeat (3) @(posedge usr_clk);
        #1;
        chk("t4_req_hold", {dmar_valid, dmar_sa, dmar_len}, {1'b1, 32'h3000, 32'd32});
        serve(2, 1);
        serve(1, 0);
        serve(3, 2);
        wait_idle();
        chk("t4_done", done_n - db, 5);
        chk("t4_nreq", rsa_q.size() - rb, 3);
        chk("t4_req1", rsa_q[rb+1], 32'h4000);
        chk("t4_req2", {rsa_q[rb+2], rlen_q[rb+2]}, {32'h5000, 32'd48});
        chk("t4_nwr", wa_q.size() - wb, 6);
        chk("t4_wa2", wa_q[wb+2], 32'h700);
        chk("t4_wa5", wa_q[wb+5], 32'h920);

        // Framing errors: early rlast, err_clr, extra beat, set beating clear.
        snap();
        push(32'h0000_6FC0, 32'h0000_0A00, 32'h80);
        serve(2, 1);
        chk("t5_err_early", err, 1'b1);
        err_clr = 1'b1;
        @(posedge usr_clk); #1;
        err_clr = 1'b0;
        chk("t5_err_clr", err, 1'b0);
        chk("t5_next_req", {dmar_valid, dmar_sa, dmar_len}, {1'b1, 32'h7000, 32'd64});
        err_clr = 1'b1;
        serve(5, 4);
        chk("t5_err_set_wins", err, 1'b1);
        err_clr = 1'b0;
        wait_idle();
        chk("t5_nwr", wa_q.size() - wb, 6);
        chk("t5_wa5", wa_q[wb+5], 32'hA50);
        chk("t5_req0_len", rlen_q[rb], 32'd64);
        chk("t5_done", done_n - db, 1);
        err_clr = 1'b1;
        @(posedge usr_clk); #1;
        err_clr = 1'b0;

        // Reset in the middle of a chunk with another command queued.
        snap();
        push(32'h0000_8000, 32'h0000_0B00, 32'd64);
        push(32'h0000_9000, 32'h0000_0C00, 32'd16);
        serve(2, -1);
        chk("t6_pre_count", cmd_count, 3'd1);
        usr_reset_n = 1'b0;
        dma_rvalid  = 1'b1;
        #1;
        chk("t6_rst_outs", {dmar_valid, dma_rready, ram_we, busy, done, err}, 6'b0);
        chk("t6_rst_ready", {cfg_ready, cmd_count}, {1'b1, 3'd0});
        @(posedge usr_clk); #1;
        dma_rvalid  = 1'b0;
        usr_reset_n = 1'b1;
        repeat (10) @(posedge usr_clk);
        #1;
        chk("t6_no_done", done_n - db, 0);
        chk("t6_flushed", {busy, dmar_valid}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
